apb_native_arbiter: RTL and testbench

APB_NATIVE_ARBITER -- requirements
Module: apb_native_arbiter

---
 rtl/apb_native_arbiter_pkg.sv | 16 +
 rtl/apb_native_arbiter_rr_picker.sv | 37 +++
 rtl/apb_native_arbiter.sv | 152 +++++++++++++++
 tb/tb_apb_native_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_native_arbiter_pkg.sv
// Shared types and constants for the native-bus to APB-converter arbiter.
// The optional watchdog is enabled by defining ARB_TIMEOUT_EN.
package apb_arb_pkg;

    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 8;
    localparam int GRANT_W         = 3;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/apb_native_arbiter_rr_picker.sv
// Combinational round-robin picker: searches from last_grant+1 upward (mod NUM_REQ)
// for the first asserted request.
module rr_picker
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [GRANT_W-1:0] winner,
    output logic               any_req
);

    logic [7:0] valid8;
    logic [3:0] idx;
    logic       found;

    always_comb begin
        valid8                = '0;
        valid8[NUM_REQ-1:0]   = req_valid;
        winner                = last_grant;
        found                 = 1'b0;
        idx                   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = {1'b0, last_grant} + 4'(off);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            if (!found && valid8[idx[2:0]]) begin
                winner = idx[2:0];
                found  = 1'b1;
            end
        end
        any_req = |req_valid;
    end

endmodule

// File: rtl/apb_native_arbiter.sv
// Arbitrates NUM_REQ native-bus requesters onto a single read/write converter port.
// Define ARB_TIMEOUT_EN to add a BUSY-state watchdog that completes stuck transfers with req_err.
module apb_native_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      req_err,
    output logic                      write_req,
    output logic                      read_req,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic [ADDR_W-1:0]         read_addr,
    input  logic                      write_ack,
    input  logic                      read_ack,
    input  logic [DATA_W-1:0]         read_data,
    output logic [GRANT_W-1:0]        grant_id
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_BUSY    = BUSY;
    localparam logic [1:0] S_RELEASE = RELEASE;

    logic [1:0]         state;
    logic [GRANT_W-1:0] winner;
    logic               any_req;
    logic               ack_match;
    logic               timeout_hit;
    logic [NUM_REQ-1:0] ack_vec;
    logic [7:0]         write_vec;
    logic [ADDR_W-1:0]  addr_arr  [8];
    logic [DATA_W-1:0]  wdata_arr [8];

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_valid  (req_valid),
        .last_grant (grant_id),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Unpack requester fields into 8-entry arrays so the 3-bit winner indexes them directly.
    always_comb begin
        write_vec              = '0;
        write_vec[NUM_REQ-1:0] = req_write;
        for (int i = 0; i < 8; i++) begin
            addr_arr[i]  = '0;
            wdata_arr[i] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
        ack_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GRANT_W'(i)) begin
                ack_vec[i] = 1'b1;
            end
        end
    end

    assign ack_match = write_req ? write_ack : read_ack;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && any_req) begin
                wd_cnt <= '0;
            end else if (state == S_BUSY) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            err_q <= (state == S_BUSY) && !ack_match && timeout_hit;
        end
    end

    assign timeout_hit = (state == S_BUSY) && (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign req_err     = err_q;
`else
    assign timeout_hit = 1'b0;
    assign req_err     = 1'b0;
`endif

    // Request outputs go low on completion and stay low through RELEASE and IDLE,
    // so the converter always sees a gap before the next grant.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= S_IDLE;
            req_ack    <= '0;
            req_rdata  <= '0;
            write_req  <= 1'b0;
            read_req   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            read_addr  <= '0;
            grant_id   <= GRANT_W'(NUM_REQ - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        state    <= S_BUSY;
                        if (write_vec[winner]) begin
                            write_req  <= 1'b1;
                            write_addr <= addr_arr[winner];
                            write_data <= wdata_arr[winner];
                        end else begin
                            read_req  <= 1'b1;
                            read_addr <= addr_arr[winner];
                        end
                    end
                end
                S_BUSY: begin
                    if (ack_match || timeout_hit) begin
                        req_ack    <= ack_vec;
                        req_rdata  <= (read_req && ack_match) ? read_data : '0;
                        write_req  <= 1'b0;
                        read_req   <= 1'b0;
                        write_addr <= '0;
                        write_data <= '0;
                        read_addr  <= '0;
                        state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    req_ack   <= '0;
                    req_rdata <= '0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_native_arbiter.sv
// Self-checking bench for apb_native_arbiter: directed scenarios then randomized traffic,
// checked against a round-robin model. Timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_apb_native_arbiter;

    localparam int N = 4;

    logic           pclk = 1'b0;
    logic           presetn;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_write;
    logic [N*8-1:0] req_addr;
    logic [N*8-1:0] req_wdata;
    logic [N-1:0]   req_ack;
    logic [7:0]     req_rdata;
    logic           req_err;
    logic           write_req;
    logic           read_req;
    logic [7:0]     write_addr;
    logic [7:0]     write_data;
    logic [7:0]     read_addr;
    logic           write_ack;
    logic           read_ack;
    logic [7:0]     read_data;
    logic [2:0]     grant_id;

    int checks   = 0;
    int failures = 0;
    int last_grant;

    apb_native_arbiter #(.NUM_REQ(N), .TIMEOUT(8)) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ack    (req_ack),
        .req_rdata  (req_rdata),
        .req_err    (req_err),
        .write_req  (write_req),
        .read_req   (read_req),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .write_ack  (write_ack),
        .read_ack   (read_ack),
        .read_data  (read_data),
        .grant_id   (grant_id)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec rule: scan (last+1) mod N, (last+2) mod N, ... and take the first valid requester.
    function automatic int model_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
        req_valid[i]       = 1'b1;
        req_write[i]       = w;
        req_addr[i*8 +: 8] = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},   req_ack, 0);
        check({tag, "_rdata"}, req_rdata, 0);
        check({tag, "_err"},   req_err, 0);
        check({tag, "_reqs"},  {write_req, read_req}, 0);
        check({tag, "_addrs"}, {write_addr, write_data, read_addr}, 0);
        check({tag, "_gid"},   grant_id, N - 1);
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!(write_req === 1'b1 || read_req === 1'b1) && n < 20) begin
            step();
            n++;
        end
        check("grant_seen", write_req | read_req, 1);
    endtask

    task automatic run_txn(input int delay, input bit mismatch, input bit withdraw,
                           input bit persistent, input logic [7:0] rd, output int g);
        logic       w;
        logic [7:0] a, d;
        g = model_pick(req_valid, last_grant);
        w = req_write[g];
        a = req_addr[g*8 +: 8];
        d = req_wdata[g*8 +: 8];
        wait_grant();
        check("grant_id", grant_id, g);
        check("req_type", {write_req, read_req}, {w, !w});
        check("wr_fields", {write_addr, write_data}, w ? {a, d} : 16'h0);
        check("rd_addr", read_addr, w ? 8'h00 : a);
        if (withdraw) req_valid[g] = 1'b0;
        if (mismatch) begin
            write_ack = !w;
            read_ack  = w;
            step();
            write_ack = 1'b0;
            read_ack  = 1'b0;
            check("ignore_wrong_ack", {req_ack, write_req, read_req}, {4'b0, w, !w});
        end
        for (int k = 0; k < delay; k++) begin
            step();
            check("busy_hold", {req_ack, write_req, read_req, write_addr, read_addr},
                  {4'b0, w, !w, w ? a : 8'h00, w ? 8'h00 : a});
        end
        write_ack = w;
        read_ack  = !w;
        read_data = rd;
        step();
        write_ack = 1'b0;
        read_ack  = 1'b0;
        check("ack_pulse", req_ack, 4'b1 << g);
        check("ack_rdata", req_rdata, w ? 8'h00 : rd);
        check("ack_err", req_err, 0);
        check("release_reqs", {write_req, read_req}, 0);
        if (!persistent) req_valid[g] = 1'b0;
        last_grant = g;
        step();
        check("ack_cleared", {req_ack, req_err}, 0);
        check("gap_reqs", {write_req, read_req}, 0);
    endtask

    initial begin
        int g;
        int order[5] = '{0, 1, 2, 3, 0};

        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        write_ack = 1'b0;
        read_ack  = 1'b0;
        read_data = '0;
        last_grant = N - 1;
        #12;
        check_reset_outputs("reset");
        @(negedge pclk);
        presetn = 1'b1;
        step();
        check("idle_no_req", {write_req, read_req, req_ack}, 0);

        // All requesters held valid: grant order must rotate from requester 0.
        for (int i = 0; i < N; i++) set_req(i, i[0], 8'(8'h40 + i), 8'(8'h50 + i));
        for (int k = 0; k < 5; k++) begin
            run_txn(0, 1'b0, 1'b0, 1'b1, 8'h77, g);
            check("rr_order", g, order[k]);
        end
        req_valid = '0;
        step();

        // Reset while BUSY: transaction is dropped without an ack.
        set_req(1, 1'b1, 8'h33, 8'h44);
        wait_grant();
        check("pre_reset_gid", grant_id, 1);
        step();
        #2;
        presetn   = 1'b0;
        req_valid = '0;
        #1;
        check_reset_outputs("mid_busy_reset");
        @(negedge pclk);
        presetn    = 1'b1;
        last_grant = N - 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("no_ack_after_reset", {req_ack, write_req, read_req}, 0);
        end

        set_req(2, 1'b1, 8'h10, 8'hA5);
        run_txn(2, 1'b0, 1'b0, 1'b0, 8'hEE, g);
        set_req(1, 1'b0, 8'h20, 8'h00);
        run_txn(1, 1'b0, 1'b0, 1'b0, 8'h3C, g);
        set_req(0, 1'b1, 8'h05, 8'h5A);
        run_txn(2, 1'b1, 1'b1, 1'b0, 8'h00, g);

`ifdef ARB_TIMEOUT_EN
        set_req(3, 1'b0, 8'h99, 8'h00);
        wait_grant();
        check("to_gid", grant_id, 3);
        for (int k = 1; k < 8; k++) begin
            step();
            check("to_waiting", {req_ack, req_err, read_req}, {4'b0, 1'b0, 1'b1});
        end
        step();
        check("to_ack", {req_ack, req_err, read_req}, {4'b1000, 1'b1, 1'b0});
        check("to_rdata", req_rdata, 0);
        req_valid[3] = 1'b0;
        last_grant   = 3;
        step();
        check("to_cleared", {req_ack, req_err}, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
            end
            if (req_valid == '0)
                set_req($urandom_range(0, N - 1), 1'($urandom), 8'($urandom), 8'($urandom));
            run_txn($urandom_range(0, 3), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0, 1'b0, 8'($urandom), g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
